// File: rtl/stack_engine_if.sv
// Command/response bus between the control FSM (master) and stack_engine (slave).
interface stack_engine_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W  = 1
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [SEL_W-1:0]  cmd_sel;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_fault;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_fault
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/stack_engine.sv
// Multi-stack storage engine: NUM_STACKS hardware stacks behind a 3-cycle command/response FSM.
// Optional STACK_STICKY_FAULT_EN: first overflow/underflow locks a stack until reset.
module stack_engine #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned NUM_STACKS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    stack_engine_if.slave         bus,
    output logic [NUM_STACKS-1:0] empty,
    output logic [NUM_STACKS-1:0] full
);
    localparam int unsigned SEL_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1;
    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] OP_PEEK = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;

    localparam logic [1:0] FLT_OK  = 2'b00;
    localparam logic [1:0] FLT_OVF = 2'b01;
    localparam logic [1:0] FLT_UNF = 2'b10;
    localparam logic [1:0] FLT_SEL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]          rsp_fault_q, rsp_fault_d;
    logic [1:0]          op_q, op_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SP_W-1:0]     sp_q [NUM_STACKS];
    logic [SP_W-1:0]     sp_d [NUM_STACKS];
    logic [NUM_STACKS-1:0] empty_q, empty_d;
    logic [NUM_STACKS-1:0] full_q, full_d;

    logic [DATA_W-1:0]   mem_q [NUM_STACKS][DEPTH];

    logic                  wr_en;
    logic [SEL_W-1:0]      wr_sel;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_W-1:0]     wr_data;
    logic [NUM_STACKS-1:0] sel_hit;
    logic                  sel_ok;
    logic [SP_W-1:0]       cur_sp, nxt_sp;
    logic [IDX_W-1:0]      top_idx;
    logic [DATA_W-1:0]     top_data;
    logic                  set_lock;
    logic [1:0]            lock_code;

`ifdef STACK_STICKY_FAULT_EN
    logic       lock_q [NUM_STACKS];
    logic       lock_d [NUM_STACKS];
    logic [1:0] code_q [NUM_STACKS];
    logic [1:0] code_d [NUM_STACKS];
    logic       cur_lock;
    logic [1:0] cur_code;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign empty         = empty_q;
    assign full          = full_q;

    // Next-state, datapath and response computation
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sel_d       = sel_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        sp_d        = sp_q;
        wr_en       = 1'b0;
        wr_sel      = sel_q;
        wr_idx      = '0;
        wr_data     = data_q;
        sel_hit     = '0;
        cur_sp      = '0;
        top_data    = '0;
        set_lock    = 1'b0;
        lock_code   = FLT_OK;
`ifdef STACK_STICKY_FAULT_EN
        lock_d   = lock_q;
        code_d   = code_q;
        cur_lock = 1'b0;
        cur_code = FLT_OK;
`endif

        for (int i = 0; i < int'(NUM_STACKS); i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_hit[i] = 1'b1;
                cur_sp     = sp_q[i];
`ifdef STACK_STICKY_FAULT_EN
                cur_lock   = lock_q[i];
                cur_code   = code_q[i];
`endif
            end
        end
        sel_ok  = |sel_hit;
        top_idx = IDX_W'(cur_sp - SP_W'(1));
        nxt_sp  = cur_sp;
        for (int i = 0; i < int'(NUM_STACKS); i++) begin
            if (sel_hit[i]) top_data = mem_q[i][top_idx];
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    sel_d   = bus.cmd_sel;
                    data_d  = bus.cmd_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_fault_d = FLT_OK;
                if (!sel_ok) begin
                    rsp_fault_d = FLT_SEL;
`ifdef STACK_STICKY_FAULT_EN
                end else if (cur_lock) begin
                    rsp_fault_d = cur_code;
`endif
                end else if (op_q == OP_PUSH && cur_sp == SP_W'(DEPTH)) begin
                    rsp_fault_d = FLT_OVF;
                    set_lock    = 1'b1;
                    lock_code   = FLT_OVF;
                end else if (op_q != OP_PUSH && cur_sp == '0) begin
                    rsp_fault_d = FLT_UNF;
                    set_lock    = 1'b1;
                    lock_code   = FLT_UNF;
                end else begin
                    case (op_q)
                        OP_PUSH: begin
                            wr_en  = 1'b1;
                            wr_idx = IDX_W'(cur_sp);
                            nxt_sp = cur_sp + SP_W'(1);
                        end
                        OP_POP: begin
                            rsp_data_d = top_data;
                            nxt_sp     = cur_sp - SP_W'(1);
                        end
                        OP_PEEK: rsp_data_d = top_data;
                        default: begin
                            rsp_data_d = top_data;
                            wr_en      = 1'b1;
                            wr_idx     = top_idx;
                        end
                    endcase
                end
                for (int i = 0; i < int'(NUM_STACKS); i++) begin
                    if (sel_hit[i]) sp_d[i] = nxt_sp;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef STACK_STICKY_FAULT_EN
        for (int i = 0; i < int'(NUM_STACKS); i++) begin
            if (set_lock && sel_hit[i]) begin
                lock_d[i] = 1'b1;
                code_d[i] = lock_code;
            end
        end
`endif

        empty_d = '0;
        full_d  = '0;
        for (int i = 0; i < int'(NUM_STACKS); i++) begin
            empty_d[i] = (sp_d[i] == '0);
            full_d[i]  = (sp_d[i] == SP_W'(DEPTH));
        end
        cmd_ready_d = (state_d == S_IDLE);
    end

    // Control, pointer and response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= FLT_OK;
            op_q        <= '0;
            sel_q       <= '0;
            data_q      <= '0;
            empty_q     <= '1;
            full_q      <= '0;
            for (int i = 0; i < int'(NUM_STACKS); i++) begin
                sp_q[i] <= '0;
`ifdef STACK_STICKY_FAULT_EN
                lock_q[i] <= 1'b0;
                code_q[i] <= FLT_OK;
`endif
            end
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            op_q        <= op_d;
            sel_q       <= sel_d;
            data_q      <= data_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            sp_q        <= sp_d;
`ifdef STACK_STICKY_FAULT_EN
            lock_q      <= lock_d;
            code_q      <= code_d;
`endif
        end
    end

    // Storage has no reset; a write in the reset cycle is dropped so an aborted push is lost
    always_ff @(posedge clk) begin
        if (rst && wr_en) mem_q[wr_sel][wr_idx] <= wr_data;
    end
endmodule

// File: doc/stack_engine.md
# stack_engine

Parametrised multi-stack storage engine for the stack-based CPU datapath. It owns NUM_STACKS independent hardware stacks (main stack, return stack, and spares) with internal storage, pointer management, and overflow/underflow/bad-select fault reporting. It replaces the separate stack-pointer registers and pop/write strobes driven by the multicycle control FSM. The control FSM issues one command per valid/ready handshake and receives a registered response.

## Interface
- DATA_W, 16, width of one stack entry
- DEPTH, 64, entries per stack (≥2)
- NUM_STACKS, 2, number of independent stacks (≥1)
- Derived: SEL_W = max(1, clog2(NUM_STACKS)); SP_W = clog2(DEPTH+1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command; high only in IDLE
- cmd_op  in  2  00 PEEK, 01 PUSH, 10 POP, 11 REPLACE (return top, overwrite it)
- cmd_sel  in  SEL_W  target stack
- cmd_data  in  DATA_W  PUSH/REPLACE write data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_data  out  DATA_W  read data (PEEK/POP/REPLACE = old top; PUSH = 0; any fault = 0)
- rsp_fault  out  2  00 ok, 01 overflow, 10 underflow, 11 bad select
- empty  out  NUM_STACKS  per-stack sp==0
- full  out  NUM_STACKS  per-stack sp==DEPTH

## Operation
- Per-stack pointer sp[SP_W] counts entries, 0..DEPTH. Top entry is at index sp-1. Storage is a NUM_STACKS×DEPTH register array and is not reset.
- The FSM has three states: IDLE → EXEC → RESP → IDLE.
  - IDLE: cmd_ready=1. When cmd_valid=1, latch op/sel/data and go to EXEC. Without cmd_valid, stay in IDLE.
  - EXEC: fault check, then the array access and sp update for the latched command.
  - RESP: drive rsp_valid=1 with rsp_data/rsp_fault, then return to IDLE.
- Fault checks, in priority order:
  - cmd_sel ≥ NUM_STACKS → 11.
  - PUSH with sp==DEPTH → 01.
  - PEEK/POP/REPLACE with sp==0 → 10.
  - On any fault, storage and every sp are unchanged.
- Command effects:
  - PUSH: mem[sel][sp] ← data, sp+1.
  - POP: return mem[sel][sp-1], sp-1.
  - PEEK: return top, sp unchanged.
  - REPLACE: return old top, mem[sel][sp-1] ← data, sp unchanged.
- Stacks are fully independent. A command to one stack never alters another stack's sp or contents.
- No wrap-around: sp saturates logically via the fault checks and never exceeds DEPTH or goes below 0.

## Timing
- Handshake is at cycle N (cmd_valid & cmd_ready).
  - EXEC is at N+1.
  - rsp_valid is high for exactly cycle N+2.
  - cmd_ready returns high at N+3.
- Throughput: one command per 3 cycles. Fault responses have the same latency.
- cmd_valid while cmd_ready=0 is ignored; no command is queued. cmd_data/sel/op need only be valid at the handshake cycle.
- empty/full are registered from sp and reflect the new sp from N+2 onward.
- Reset values, with rst=0 at a rising edge:
  - cmd_ready=1 (IDLE), rsp_valid=0, rsp_data=0, rsp_fault=00.
  - all sp=0, empty=all ones, full=all zeros.
- Reset mid-operation (EXEC or RESP): the command is aborted, no rsp_valid is issued, all sp clear, and the engine is in IDLE the next cycle. A push aborted in EXEC is lost.

## Configuration
- STACK_STICKY_FAULT_EN defined:
  - Each stack has a lock bit plus a stored 2-bit code, set by its first overflow/underflow fault.
  - Every later command to a locked stack skips the access and responds with the stored code and rsp_data=0.
  - Locks clear only on reset. Bad-select faults never lock.
- STACK_STICKY_FAULT_EN undefined: faults are reported per command only, with no retained state.

## Test plan
Configuration for all scenarios: DATA_W=16, DEPTH=4, NUM_STACKS=3 (SEL_W=2).
- Reset: hold rst=0 for 2 cycles → cmd_ready=1, rsp_valid=0, empty=3'b111, full=3'b000.
- Push and read back on stack 0:
  - PUSH 0x1111, then PUSH 0x2222.
  - PEEK → 0x2222/00.
  - POP → 0x2222/00, then POP → 0x1111/00.
  - empty[0]=1.
  - Each rsp_valid lands exactly 2 cycles after its handshake.
- Overflow on stack 1:
  - 4 PUSHes 0xA0..0xA3 → full[1]=1.
  - 5th PUSH 0xA4 → fault 01, data 0.
  - POP → 0x00A3.
  - Stack 0 is unaffected.
- Underflow, bad select, REPLACE:
  - POP on empty stack 2 → fault 10, data 0.
  - cmd_sel=3 → fault 11.
  - PUSH 0xAAAA then REPLACE 0xBBBB → 0xAAAA/00; then PEEK → 0xBBBB, sp still 1.
- Reset mid-op: assert rst=0 in the EXEC cycle of a PUSH → no rsp_valid, empty all ones, cmd_ready=1 after release.
- Sticky faults, with STACK_STICKY_FAULT_EN defined:
  - Underflow on stack 0.
  - PUSH 0x1234 to stack 0 → fault 10, empty[0] still 1.
  - Stack 1 commands behave normally.
  - After reset, PUSH to stack 0 succeeds.
